// File: rtl/i2c_passthru_bitrx_pkg.sv
// Shared state encoding and default f_ref timing for the passthru bit receiver.
package i2c_passthru_bitrx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScl0,
    StScl1High,
    StScl1Mid,
    StBusFree,
    StViolation
  } state_e;

  localparam int unsigned FRefTSuDatDef = 2;
  localparam int unsigned FRefTLowDef   = 38;

endpackage

// File: rtl/i2c_passthru_bitrx_ref_timer.sv
// Counts f_ref rising edges down from LOAD after every reload, saturating at zero.
module i2c_passthru_bitrx_ref_timer #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LOAD  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic f_ref_i,
  input  logic reload_i,
  output logic zero_o
);

  logic             f_ref_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick;

  always_comb begin
    tick    = f_ref_i & ~f_ref_q;
    count_d = count_q;
    if (reload_i) begin
      count_d = WIDTH'(LOAD);
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_ref_q <= 1'b0;
      count_q <= '0;
    end else begin
      f_ref_q <= f_ref_i;
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/i2c_passthru_bitrx.sv
// Bit-level I2C receiver: samples one bit period from the driving side and stretches SCL between
// bits until the paired transmitter asks for the next one.
module i2c_passthru_bitrx
  import i2c_passthru_bitrx_pkg::*;
#(
  parameter int unsigned F_REF_T_SU_DAT       = FRefTSuDatDef,
  parameter int unsigned F_REF_T_LOW          = FRefTLowDef,
  parameter int unsigned WIDTH_F_REF_T_SU_DAT = $clog2(F_REF_T_SU_DAT + 1),
  parameter int unsigned WIDTH_F_REF_T_LOW    = $clog2(F_REF_T_LOW + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_f_ref,
  input  logic i_start_rx,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda_init_valid,
  output logic o_sda_init,
  output logic o_sda_mid_change,
  output logic o_sda_final,
  output logic o_done,
  output logic o_violation
);

  state_e state_q, state_d;
  logic   sda_q;
  logic   scl_q, scl_d;
  logic   init_q, init_d;
  logic   init_valid_q, init_valid_d;
  logic   mid_q, mid_d;
  logic   sda_final_q, sda_final_d;
  logic   done_q, done_d;
  logic   viol_q, viol_d;
  logic   sda_chg, su_load, tl_load, su_zero, tl_zero;

  i2c_passthru_bitrx_ref_timer #(
    .WIDTH(WIDTH_F_REF_T_SU_DAT),
    .LOAD (F_REF_T_SU_DAT)
  ) u_su_dat_timer (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .f_ref_i (i_f_ref),
    .reload_i(sda_chg | su_load),
    .zero_o  (su_zero)
  );

  i2c_passthru_bitrx_ref_timer #(
    .WIDTH(WIDTH_F_REF_T_LOW),
    .LOAD (F_REF_T_LOW)
  ) u_t_low_timer (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .f_ref_i (i_f_ref),
    .reload_i(sda_chg | tl_load),
    .zero_o  (tl_zero)
  );

  always_comb begin
    state_d      = state_q;
    init_d       = init_q;
    init_valid_d = init_valid_q;
    mid_d        = mid_q;
    sda_final_d  = sda_final_q;
    done_d       = done_q;
    viol_d       = viol_q;
    su_load      = 1'b0;
    tl_load      = 1'b0;
    sda_chg      = (i_sda != sda_q);

    unique case (state_q)
      StIdle: begin
        if (i_start_rx) begin
          state_d      = StScl0;
          mid_d        = 1'b0;
          init_valid_d = 1'b0;
          done_d       = 1'b0;
          su_load      = 1'b1;
        end
      end
      StScl0: begin
        if (i_scl) begin
          if (init_valid_q) begin
            state_d = StScl1High;
          end else begin
            state_d = StViolation;
          end
        end else begin
          init_d       = i_sda;
          init_valid_d = su_zero & ~sda_chg;
        end
      end
      StScl1High: begin
        // SCL fall is checked first so a coincident SDA toggle belongs to the next bit.
        if (!i_scl) begin
          sda_final_d = init_q;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else if (i_sda != init_q) begin
          mid_d   = 1'b1;
          tl_load = 1'b1;
          state_d = StScl1Mid;
        end
      end
      StScl1Mid: begin
        if (!i_scl) begin
          sda_final_d = sda_q;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else if (sda_chg) begin
          state_d = StViolation;
        end else if (tl_zero) begin
          sda_final_d = i_sda;
          done_d      = 1'b1;
          state_d     = StBusFree;
        end
      end
      StBusFree: begin
        if (!i_scl) begin
          state_d = StViolation;
        end else if (sda_chg && !i_sda) begin
          init_d  = 1'b1;
          mid_d   = 1'b1;
          done_d  = 1'b0;
          tl_load = 1'b1;
          state_d = StScl1Mid;
        end
      end
      StViolation: ;
      default: state_d = StViolation;
    endcase

    if (state_d == StViolation) begin
      viol_d = 1'b1;
      done_d = 1'b0;
    end
    scl_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StScl1High;
      sda_q        <= 1'b1;
      scl_q        <= 1'b1;
      init_q       <= 1'b1;
      init_valid_q <= 1'b1;
      mid_q        <= 1'b0;
      sda_final_q  <= 1'b1;
      done_q       <= 1'b0;
      viol_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sda_q        <= i_sda;
      scl_q        <= scl_d;
      init_q       <= init_d;
      init_valid_q <= init_valid_d;
      mid_q        <= mid_d;
      sda_final_q  <= sda_final_d;
      done_q       <= done_d;
      viol_q       <= viol_d;
    end
  end

  assign o_scl            = scl_q;
  assign o_sda_init_valid = init_valid_q;
  assign o_sda_init       = init_q;
  assign o_sda_mid_change = mid_q;
  assign o_sda_final      = sda_final_q;
  assign o_done           = done_q;
  assign o_violation      = viol_q;

endmodule

// File: tb/tb_i2c_passthru_bitrx.sv
// Directed/randomised bench for i2c_passthru_bitrx; expectations come from bit-level I2C rules.
module tb_i2c_passthru_bitrx;

  localparam int unsigned TSuDat = 2;
  localparam int unsigned TLow   = 38;

  logic clk = 1'b0;
  logic rst, f_ref, start_rx, scl, sda;
  logic o_scl, o_valid, o_init, o_mid, o_final, o_done, o_viol;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_passthru_bitrx dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_f_ref         (f_ref),
    .i_start_rx      (start_rx),
    .i_scl           (scl),
    .i_sda           (sda),
    .o_scl           (o_scl),
    .o_sda_init_valid(o_valid),
    .o_sda_init      (o_init),
    .o_sda_mid_change(o_mid),
    .o_sda_final     (o_final),
    .o_done          (o_done),
    .o_violation     (o_viol)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // One f_ref period = one rising edge, spread over two clocks.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      f_ref = 1'b1;
      step();
      f_ref = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic with_start);
    rst = 1'b1; scl = 1'b1; sda = 1'b1; start_rx = with_start;
    step();
    chk("rst_scl", o_scl, 1'b1);
    chk("rst_init", o_init, 1'b1);
    chk("rst_valid", o_valid, 1'b1);
    chk("rst_mid", o_mid, 1'b0);
    chk("rst_final", o_final, 1'b1);
    chk("rst_done", o_done, 1'b0);
    chk("rst_viol", o_viol, 1'b0);
    rst = 1'b0; start_rx = 1'b0;
  endtask

  // From idle-bus state (SCL high, SDA high) let SCL fall: empty bit, ends stretched.
  task automatic go_idle();
    scl = 1'b0;
    step();
    chk("idle_done", o_done, 1'b1);
    chk("idle_scl", o_scl, 1'b0);
    chk("idle_final", o_final, 1'b1);
  endtask

  task automatic begin_bit(input logic b, input int nt);
    start_rx = 1'b1;
    step();
    start_rx = 1'b0;
    chk("start_scl", o_scl, 1'b1);
    chk("start_done", o_done, 1'b0);
    chk("start_mid", o_mid, 1'b0);
    chk("start_valid", o_valid, 1'b0);
    sda = b;
    step();
    tick(nt);
    chk("su_valid", o_valid, (nt >= TSuDat));
    chk("su_init", o_init, b);
    scl = 1'b1;
    step();
  endtask

  // kind 0: plain bit; 1: one mid toggle; 2: two toggles; 3: SCL fall with coincident toggle.
  task automatic run_bit(input int kind, input logic b, input int nt);
    begin_bit(b, nt);
    if (nt < TSuDat) begin
      chk("setup_viol", o_viol, 1'b1);
      chk("setup_viol_done", o_done, 1'b0);
      sda = ~sda;
      step(3);
      chk("viol_sticky", o_viol, 1'b1);
      do_reset(1'b0);
      go_idle();
      return;
    end
    chk("rise_viol", o_viol, 1'b0);
    chk("rise_done", o_done, 1'b0);
    case (kind)
      0: begin
        scl = 1'b0;
        step();
        chk("bit_done", o_done, 1'b1);
        chk("bit_init", o_init, b);
        chk("bit_final", o_final, b);
        chk("bit_mid", o_mid, 1'b0);
        chk("bit_scl", o_scl, 1'b0);
      end
      1: begin
        sda = ~b;
        step();
        chk("mid_flag", o_mid, 1'b1);
        scl = 1'b0;
        step();
        chk("mid_done", o_done, 1'b1);
        chk("mid_final", o_final, ~b);
        chk("mid_init", o_init, b);
      end
      2: begin
        sda = ~b;
        step();
        sda = b;
        step();
        chk("dbl_viol", o_viol, 1'b1);
        chk("dbl_scl", o_scl, 1'b1);
        do_reset(1'b0);
        go_idle();
      end
      default: begin
        scl = 1'b0;
        sda = ~b;
        step();
        chk("coinc_done", o_done, 1'b1);
        chk("coinc_mid", o_mid, 1'b0);
        chk("coinc_final", o_final, b);
      end
    endcase
  endtask

  // Bit 0 turned into a STOP; bus is free only if SDA stays high for TLow ticks.
  task automatic run_stop(input int nt);
    begin_bit(1'b0, TSuDat);
    sda = 1'b1;
    step();
    chk("stop_mid", o_mid, 1'b1);
    tick(nt);
    chk("stop_done", o_done, (nt >= TLow));
    chk("stop_scl", o_scl, 1'b1);
    if (nt >= TLow) begin
      chk("stop_final", o_final, 1'b1);
      sda = 1'b0;
      step();
      chk("restart_mid", o_mid, 1'b1);
      chk("restart_done", o_done, 1'b0);
      chk("restart_init", o_init, 1'b1);
      scl = 1'b0;
      step();
      chk("restart_bit_done", o_done, 1'b1);
      chk("restart_final", o_final, 1'b0);
    end else begin
      scl = 1'b0;
      step();
      chk("short_done", o_done, 1'b1);
      chk("short_final", o_final, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; f_ref = 1'b0; start_rx = 1'b0; scl = 1'b1; sda = 1'b1;
    step(2);
    do_reset(1'b0);
    sda = 1'b0;
    step();
    chk("start_cond_mid", o_mid, 1'b1);
    chk("start_cond_done", o_done, 1'b0);
    scl = 1'b0;
    step();
    chk("start_cond_bit_done", o_done, 1'b1);
    chk("start_cond_final", o_final, 1'b0);
    chk("start_cond_stretch", o_scl, 1'b0);
    step(4);
    chk("stretch_held", o_scl, 1'b0);

    run_bit(0, 1'b0, 3);
    run_bit(0, 1'b1, TSuDat);
    run_bit(0, 1'b0, 1);
    run_stop(40);
    run_stop(TLow - 1);
    run_stop(TLow);

    // Reset in the middle of a mid-change bit.
    begin_bit(1'b1, TSuDat);
    sda = 1'b0;
    step();
    chk("pre_rst_mid", o_mid, 1'b1);
    do_reset(1'b0);
    go_idle();

    // Reset and start_rx together: reset wins.
    do_reset(1'b1);
    go_idle();

    for (int i = 0; i < 20; i++) begin
      run_bit(int'($urandom % 4), logic'($urandom % 2), int'($urandom_range(0, 4)));
    end
    for (int i = 0; i < 3; i++) begin
      run_stop(int'($urandom_range(30, 45)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
